gmii_speed_sel: RTL and testbench
=================================

GMII_SPEED_SEL -- requirements
Module: gmii_speed_sel

Interface
REQ-001 Parameter NCH, default 2: number of independent GMII channels, legal range 1..8.
REQ-002 Parameter TIMER_W, default 28: width of the per-channel hold timer.
REQ-003 Parameter HOLD_CNT, default 28'h0ffffff: hold-timer terminal count; elaboration SHALL fail if HOLD_CNT >= 2**TIMER_W.
REQ-004 Parameter ACK_TO, default 255: maximum cycles to wait for a switch acknowledge; 8-bit counter.
REQ-005 Parameter SYNC_STAGES, default 2: synchroniser depth for ge_ind, legal range 2..4.
REQ-006 clk_125M  in  1  sole clock; the 125 MHz GTX reference.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 ge_ind  in  NCH  per-channel PHY gigabit indication; asynchronous to clk_125M.
REQ-009 sw_ack  in  NCH  per-channel acknowledge from the external glitch-free TX clock mux.
REQ-010 chg_clr  in  NCH  per-channel clear of chg_flag; active-high, one cycle.
REQ-011 sel_ge  out  NCH  per-channel TX clock select: 1 = clk_125M, 0 = PHY TXCLK.
REQ-012 sw_req  out  NCH  per-channel request to the clock mux to change its selection.
REQ-013 ack_err  out  NCH  sticky flag: a switch completed by timeout, not by acknowledge.
REQ-014 chg_flag  out  NCH  sticky flag: sel_ge changed.
REQ-015 irq  out  1  interrupt; OR of all chg_flag bits.

Function
REQ-016 Each channel SHALL pass ge_ind through SYNC_STAGES flops to form ge_s; all FSM decisions SHALL use ge_s only.
REQ-017 Each channel SHALL run an independent FSM with states FE, GE, HOLD and SW, plus a target bit tgt.
REQ-018 FE: ge_s=1 -> SW with tgt=1 on the next cycle; otherwise stay.
REQ-019 GE: ge_s=0 -> HOLD, with the timer cleared to 0.
REQ-020 HOLD: ge_s=1 -> GE, timer cleared; else if timer==HOLD_CNT -> SW with tgt=0; else timer increments by 1.
REQ-021 sw_req SHALL be 1 exactly while the channel is in SW.
REQ-022 SW: sw_ack=1 -> on the next clock sel_ge<=tgt, go to GE if tgt=1 else FE, and the ack counter clears.
REQ-023 SW: the ack counter increments each cycle without sw_ack; on reaching ACK_TO, ack_err<=1, and sel_ge and the state update as in REQ-022.
REQ-024 ge_s changes during SW SHALL be ignored; the destination state re-evaluates ge_s on its first cycle.
REQ-025 A sw_ack received outside SW SHALL be ignored.
REQ-026 Latency: a ge_ind rise in FE SHALL assert sw_req SYNC_STAGES+1 cycles later.
REQ-027 Latency: a sustained ge_ind drop in GE SHALL assert sw_req SYNC_STAGES+HOLD_CNT+2 cycles later.
REQ-028 A ge_s pulse shorter than HOLD_CNT+1 low cycles while in GE/HOLD SHALL NOT change sel_ge.
REQ-029 Timer and ack counter SHALL saturate at their terminal counts and never wrap.
REQ-030 chg_flag[i] SHALL set on any cycle where sel_ge[i] changes; chg_clr[i] clears it; a simultaneous set and clear leaves it set.
REQ-031 irq SHALL be combinational from the registered chg_flag bits.

Reset
REQ-032 reset=1 SHALL asynchronously force state FE, tgt=0, sel_ge=0, sw_req=0, ack_err=0, chg_flag=0, timers, counters and synchronisers to 0.
REQ-033 reset asserted mid-SW SHALL drop sw_req immediately; the external mux SHALL see a deasserted request.
REQ-034 After reset release, the first FSM evaluation SHALL occur on the first rising clk_125M edge.

Configuration
REQ-035 With macro GMII_SPEED_IRQ_EN defined, chg_flag, chg_clr and irq SHALL behave per REQ-030/REQ-031.
REQ-036 With GMII_SPEED_IRQ_EN undefined, chg_flag and irq SHALL be tied to 0, chg_clr SHALL be ignored, and no flag registers SHALL be built.

Verification
REQ-037 Bench parameters: NCH=2, HOLD_CNT=15, ACK_TO=7, SYNC_STAGES=2, GMII_SPEED_IRQ_EN defined.
REQ-038 Scenario 1: ch0 ge_ind 0->1, sw_ack returned 2 cycles after sw_req -> sw_req rises 3 cycles after ge_ind; sel_ge[0]=1 one cycle after ack; chg_flag[0]=1; irq=1.
REQ-039 Scenario 2: ch0 in GE, ge_ind low for 10 cycles then high -> no sw_req; sel_ge[0] stays 1.
REQ-040 Scenario 3: ch0 in GE, ge_ind held low -> sw_req rises 19 cycles after the drop; ack returned -> sel_ge[0]=0.
REQ-041 Scenario 4: ch1 switch with sw_ack never driven -> after 7 cycles in SW, sel_ge[1] toggles, ack_err[1]=1, and ack_err remains 1 until reset.
REQ-042 Scenario 5: reset asserted during SW on ch0 -> sw_req[0], sel_ge[0] and chg_flag[0] are 0 without a clock edge; ch1 is unaffected until reset.
REQ-043 Scenario 6: chg_clr[0] coincident with a sel_ge[0] change -> chg_flag[0]=1; a later chg_clr[0] alone -> chg_flag[0]=0 and irq=0.

Source files
------------

// File: rtl/gmii_speed_sel.sv
// rtl/gmii_speed_sel.sv - per-channel GMII TX clock speed selector with hold-off and clock-mux handshake
// Optional feature macro: GMII_SPEED_IRQ_EN (sticky chg_flag bits, chg_clr and irq)
module gmii_speed_sel #(
  parameter int          NCH         = 2,
  parameter int          TIMER_W     = 28,
  parameter int unsigned HOLD_CNT    = 28'h0ffffff,
  parameter int unsigned ACK_TO      = 255,
  parameter int          SYNC_STAGES = 2
) (
  input  logic           clk_125M,
  input  logic           reset,
  input  logic [NCH-1:0] ge_ind,
  input  logic [NCH-1:0] sw_ack,
  input  logic [NCH-1:0] chg_clr,
  output logic [NCH-1:0] sel_ge,
  output logic [NCH-1:0] sw_req,
  output logic [NCH-1:0] ack_err,
  output logic [NCH-1:0] chg_flag,
  output logic           irq
);

  generate
    if (NCH < 1 || NCH > 8) begin : g_bad_nch
      $error("gmii_speed_sel: NCH must be 1..8");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("gmii_speed_sel: SYNC_STAGES must be 2..4");
    end
    if (TIMER_W < 33 && (64'(HOLD_CNT) >= (64'd1 << TIMER_W))) begin : g_bad_hold
      $error("gmii_speed_sel: HOLD_CNT does not fit in TIMER_W bits");
    end
    if (ACK_TO > 255) begin : g_bad_ack
      $error("gmii_speed_sel: ACK_TO must fit in 8 bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_FE   = 2'd0,
    ST_GE   = 2'd1,
    ST_HOLD = 2'd2,
    ST_SW   = 2'd3
  } state_t;

  localparam logic [TIMER_W-1:0] L_HOLD = TIMER_W'(HOLD_CNT);
  localparam logic [7:0]         L_ACK  = 8'(ACK_TO);

  logic [NCH-1:0] w_sel_chg;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic                   r_tgt;
    logic [TIMER_W-1:0]     r_timer;
    logic [7:0]             r_ack_cnt;
    logic                   r_sel;
    logic                   r_req;
    logic                   r_err;
    logic                   w_ge_s;
    logic                   w_ack_to;
    logic                   w_done;

    assign w_ge_s = r_sync[SYNC_STAGES-1];
    // Timeout fires on the edge the counter would reach ACK_TO, so the request lasts ACK_TO cycles.
    assign w_ack_to = (({1'b0, r_ack_cnt} + 9'd1) >= {1'b0, L_ACK});
    assign w_done   = (r_state == ST_SW) && (sw_ack[g] || w_ack_to);
    assign w_sel_chg[g] = w_done && (r_tgt != r_sel);

    always_ff @(posedge clk_125M or posedge reset) begin
      if (reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], ge_ind[g]};
      end
    end

    always_ff @(posedge clk_125M or posedge reset) begin
      if (reset) begin
        r_state   <= ST_FE;
        r_tgt     <= 1'b0;
        r_timer   <= '0;
        r_ack_cnt <= '0;
        r_sel     <= 1'b0;
        r_req     <= 1'b0;
        r_err     <= 1'b0;
      end else begin
        case (r_state)
          ST_FE: begin
            if (w_ge_s) begin
              r_state   <= ST_SW;
              r_tgt     <= 1'b1;
              r_req     <= 1'b1;
              r_ack_cnt <= '0;
            end
          end
          ST_GE: begin
            if (!w_ge_s) begin
              r_state <= ST_HOLD;
              r_timer <= '0;
            end
          end
          ST_HOLD: begin
            if (w_ge_s) begin
              r_state <= ST_GE;
              r_timer <= '0;
            end else if (r_timer == L_HOLD) begin
              r_state   <= ST_SW;
              r_tgt     <= 1'b0;
              r_req     <= 1'b1;
              r_ack_cnt <= '0;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          ST_SW: begin
            // ge_s is deliberately not looked at here; the destination state re-evaluates it.
            if (w_done) begin
              r_sel     <= r_tgt;
              r_state   <= r_tgt ? ST_GE : ST_FE;
              r_req     <= 1'b0;
              r_ack_cnt <= '0;
              if (!sw_ack[g]) begin
                r_err <= 1'b1;
              end
            end else begin
              r_ack_cnt <= r_ack_cnt + 8'd1;
            end
          end
          default: begin
            r_state <= ST_FE;
            r_req   <= 1'b0;
          end
        endcase
      end
    end

    assign sel_ge[g]  = r_sel;
    assign sw_req[g]  = r_req;
    assign ack_err[g] = r_err;
  end

`ifdef GMII_SPEED_IRQ_EN
  logic [NCH-1:0] r_chg_flag;

  // A set in the same cycle as a clear wins, so no change event is lost.
  always_ff @(posedge clk_125M or posedge reset) begin
    if (reset) begin
      r_chg_flag <= '0;
    end else begin
      r_chg_flag <= (r_chg_flag & ~chg_clr) | w_sel_chg;
    end
  end

  assign chg_flag = r_chg_flag;
  assign irq      = |r_chg_flag;
`else
  logic w_unused;

  assign w_unused = ^{chg_clr, w_sel_chg};
  assign chg_flag = '0;
  assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_speed_sel.sv
// tb/tb_gmii_speed_sel.sv - self-checking bench for gmii_speed_sel with a cycle-level behavioural model
module tb_gmii_speed_sel;

  localparam int NCH  = 2;
  localparam int HOLD = 15;
  localparam int ACKT = 7;
  localparam int SYNC = 2;
`ifdef GMII_SPEED_IRQ_EN
  localparam bit L_IRQ_EN = 1'b1;
`else
  localparam bit L_IRQ_EN = 1'b0;
`endif

  logic           clk_125M = 1'b0;
  logic           reset    = 1'b1;
  logic [NCH-1:0] ge_ind   = '0;
  logic [NCH-1:0] sw_ack   = '0;
  logic [NCH-1:0] chg_clr  = '0;
  logic [NCH-1:0] sel_ge;
  logic [NCH-1:0] sw_req;
  logic [NCH-1:0] ack_err;
  logic [NCH-1:0] chg_flag;
  logic           irq;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_125M = ~clk_125M;

  gmii_speed_sel #(
    .NCH(NCH), .TIMER_W(28), .HOLD_CNT(HOLD), .ACK_TO(ACKT), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_125M(clk_125M), .reset(reset), .ge_ind(ge_ind), .sw_ack(sw_ack),
    .chg_clr(chg_clr), .sel_ge(sel_ge), .sw_req(sw_req), .ack_err(ack_err),
    .chg_flag(chg_flag), .irq(irq)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: channel is idle-slow when sel=0, idle-fast when sel=1; a request follows
  // a synced high in slow mode, or HOLD+2 consecutive synced lows in fast mode.
  bit [NCH-1:0]  m_sel = '0, m_req = '0, m_err = '0, m_flag = '0;
  bit [SYNC-1:0] m_hist [NCH];
  int            m_low [NCH];
  int            m_swc [NCH];
  bit            m_ges;

  always @(posedge clk_125M or posedge reset) begin
    if (reset) begin
      m_sel = '0; m_req = '0; m_err = '0; m_flag = '0;
      for (int c = 0; c < NCH; c++) begin
        m_hist[c] = '0; m_low[c] = 0; m_swc[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_ges = m_hist[c][SYNC-1];
        m_hist[c] = {m_hist[c][SYNC-2:0], ge_ind[c]};
        if (chg_clr[c]) m_flag[c] = 1'b0;
        if (m_req[c]) begin
          m_swc[c]++;
          if (sw_ack[c] || m_swc[c] >= ACKT) begin
            if (!sw_ack[c]) m_err[c] = 1'b1;
            m_sel[c]  = ~m_sel[c];
            m_flag[c] = 1'b1;
            m_req[c]  = 1'b0;
            m_low[c]  = 0;
          end
        end else if (!m_sel[c]) begin
          if (m_ges) begin
            m_req[c] = 1'b1;
            m_swc[c] = 0;
          end
        end else begin
          m_low[c] = m_ges ? 0 : m_low[c] + 1;
          if (m_low[c] == HOLD + 2) begin
            m_req[c] = 1'b1;
            m_swc[c] = 0;
            m_low[c] = 0;
          end
        end
      end
    end
  end

  always @(posedge clk_125M) begin
    logic [8:0] exp_v;
    #2;
    exp_v = {m_sel, m_req, m_err, (L_IRQ_EN ? m_flag : 2'b00), (L_IRQ_EN ? |m_flag : 1'b0)};
    chk("cycle_model", 32'({sel_ge, sw_req, ack_err, chg_flag, irq}), 32'(exp_v));
  end

  task automatic wait_req(input int ch, input int maxc, output int n);
    n = 0;
    do begin
      @(posedge clk_125M); #2;
      n++;
    end while (!sw_req[ch] && n < maxc);
  endtask

  initial begin
    int n;
    int hits;
    #1;
    chk("reset_state", 32'({sel_ge, sw_req, ack_err, chg_flag, irq}), 32'd0);
    repeat (3) @(negedge clk_125M);
    reset = 1'b0;
    repeat (3) @(negedge clk_125M);

    // Scenario 1: rise on ch0, ack two cycles after the request
    ge_ind[0] = 1'b1;
    wait_req(0, 10, n);
    chk("s1_req_latency", n, 3);
    @(negedge clk_125M);
    @(negedge clk_125M);
    chk("s1_sel_before_ack", sel_ge[0], 0);
    sw_ack[0] = 1'b1;
    @(posedge clk_125M); #2;
    chk("s1_sel_after_ack", sel_ge[0], 1);
    chk("s1_req_dropped", sw_req[0], 0);
    chk("s1_chg_flag", chg_flag[0], L_IRQ_EN);
    chk("s1_irq", irq, L_IRQ_EN);
    @(negedge clk_125M);
    sw_ack[0] = 1'b0;
    repeat (5) @(negedge clk_125M);

    // Scenario 2: 10-cycle low glitch in GE must not switch
    ge_ind[0] = 1'b0;
    repeat (10) @(negedge clk_125M);
    ge_ind[0] = 1'b1;
    hits = 0;
    repeat (30) begin
      @(posedge clk_125M); #2;
      if (sw_req[0]) hits++;
    end
    chk("s2_no_req", hits, 0);
    chk("s2_sel_kept", sel_ge[0], 1);

    // Scenario 3: sustained drop
    @(negedge clk_125M);
    ge_ind[0] = 1'b0;
    wait_req(0, 40, n);
    chk("s3_req_latency", n, 19);
    @(negedge clk_125M);
    sw_ack[0] = 1'b1;
    @(posedge clk_125M); #2;
    chk("s3_sel_fe", sel_ge[0], 0);
    @(negedge clk_125M);
    sw_ack[0] = 1'b0;

    // Scenario 4: ch1 ack timeout, stray ack afterwards
    ge_ind[1] = 1'b1;
    wait_req(1, 10, n);
    chk("s4_req_latency", n, 3);
    n = 0;
    while (sw_req[1] && n < 30) begin
      @(posedge clk_125M); #2;
      n++;
    end
    chk("s4_sw_cycles", n, 7);
    chk("s4_sel_toggled", sel_ge[1], 1);
    chk("s4_ack_err", ack_err[1], 1);
    chk("s4_ch0_no_err", ack_err[0], 0);
    repeat (5) @(negedge clk_125M);
    sw_ack[1] = 1'b1;
    @(negedge clk_125M);
    sw_ack[1] = 1'b0;
    repeat (10) @(negedge clk_125M);
    chk("s4_err_sticky", ack_err[1], 1);
    chk("s4_stray_ack_ignored", {sel_ge[1], sw_req[1]}, 2'b10);

    // Scenario 6: clear coincident with a change, then a lone clear
    chg_clr = 2'b11;
    @(posedge clk_125M); #2;
    chk("s6_flags_cleared", {chg_flag, irq}, 3'b000);
    @(negedge clk_125M);
    chg_clr = 2'b00;
    ge_ind[0] = 1'b1;
    wait_req(0, 10, n);
    chk("s6_req_latency", n, 3);
    @(negedge clk_125M);
    sw_ack[0]  = 1'b1;
    chg_clr[0] = 1'b1;
    @(posedge clk_125M); #2;
    chk("s6_sel_ge", sel_ge[0], 1);
    chk("s6_set_beats_clr", chg_flag[0], L_IRQ_EN);
    @(negedge clk_125M);
    sw_ack[0]  = 1'b0;
    chg_clr[0] = 1'b0;
    repeat (3) @(negedge clk_125M);
    chg_clr[0] = 1'b1;
    @(posedge clk_125M); #2;
    chk("s6_lone_clr", {chg_flag[0], irq}, 2'b00);
    @(negedge clk_125M);
    chg_clr[0] = 1'b0;

    // Scenario 5: async reset in the middle of a ch0 switch
    ge_ind[0] = 1'b0;
    wait_req(0, 40, n);
    chk("s5_req_latency", n, 19);
    chk("s5_ch1_before_reset", {sel_ge[1], ack_err[1]}, 2'b11);
    @(negedge clk_125M);
    #1;
    reset  = 1'b1;
    ge_ind = 2'b00;
    #1;
    chk("s5_async_ch0", {sw_req[0], sel_ge[0], chg_flag[0]}, 3'b000);
    chk("s5_async_ch1", {sel_ge[1], ack_err[1]}, 2'b00);
    @(negedge clk_125M);
    reset = 1'b0;
    repeat (5) @(negedge clk_125M);
    chk("s5_post_reset_idle", 32'({sel_ge, sw_req, ack_err, chg_flag, irq}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
